reu_xfer_seq: RTL and testbench
===============================

REU_XFER_SEQ -- requirements
Module: reu_xfer_seq

Interface
REQ-001 SHALL have ports: PHI2 in 1, sole clock, all state updates on falling edge.
REQ-002 SHALL have ports: Reset in 1, synchronous, active-high.
REQ-003 SHALL have ports: Start in 1, one-cycle pulse when Execute is written to 1.
REQ-004 SHALL have ports: FF00Decode in 1, arm-and-wait mode enable.
REQ-005 SHALL have ports: FF00Hit in 1, one-cycle pulse on CPU write to $FF00.
REQ-006 SHALL have ports: XferType in 2, 00 stash, 01 fetch, 10 swap, 11 verify.
REQ-007 SHALL have ports: Length1 in 1, length register equals 1.
REQ-008 SHALL have ports: BA in 1, C64 bus available (high) during DMA.
REQ-009 SHALL have ports: C64DI in 8, C64 read data; REUDI in 8, REU RAM read data.
REQ-010 SHALL have outputs: nDMA 1, C64AOE 1, C64RnW 1, C64DO 8, C64DOE 1, REURD 1, REUWR 1, REUDO 8, NextCA 1, NextREUA 1, XferEnd 1, VerifyErr 1, Busy 1.

Function
REQ-011 SHALL implement states IDLE, ARM, C64RD, REURD, C64WR, REUWR, with one PHI2 cycle per state.
REQ-012 IDLE: on Start, SHALL go to ARM if FF00Decode=1, else to the first access state; Start while Busy SHALL be ignored.
REQ-013 ARM: SHALL hold nDMA=1 until FF00Hit, then go to the first access state.
REQ-014 Byte sequence per type SHALL be: stash C64RD->REUWR; fetch REURD->C64WR; swap C64RD->REURD->C64WR->REUWR; verify C64RD->REURD.
REQ-015 nDMA SHALL be 0 in every state except IDLE and ARM.
REQ-016 C64RD/C64WR SHALL stall in place (no strobe) while BA=0; REU states SHALL never stall.
REQ-017 C64RD SHALL latch C64DI into byte latch A; REURD SHALL latch REUDI into latch B; REUDO SHALL be A and C64DO SHALL be B.
REQ-018 C64AOE SHALL be 1 in C64 states with BA=1; C64RnW SHALL be 0 only in C64WR; C64DOE SHALL be 1 only in C64WR.
REQ-019 REURD and REUWR SHALL be 1 only in their states.
REQ-020 In the last state of a byte with Length1=0, the block SHALL pulse NextCA and NextREUA for one cycle and restart the sequence.
REQ-021 In the last state of a byte with Length1=1, the block SHALL pulse XferEnd, SHALL NOT pulse NextCA/NextREUA, and SHALL return to IDLE.
REQ-022 Verify: the REURD cycle SHALL compare REUDI with latch A; on mismatch it SHALL pulse VerifyErr, SHALL NOT pulse XferEnd/NextCA/NextREUA, and SHALL go to IDLE; VerifyErr SHALL take priority over end-of-length.
REQ-023 Busy SHALL be 1 in every state except IDLE.
REQ-024 All outputs SHALL be registered and glitch-free on the falling edge of PHI2.

Reset
REQ-025 Reset SHALL force IDLE, nDMA=1, C64RnW=1, all other outputs 0, and latches A/B to 00, including during a transfer.
REQ-026 Reset SHALL take priority over Start and FF00Hit in the same cycle.

Structure
REQ-027 The state enum and the XferType codes SHALL live in shared package reu_pkg.
REQ-028 No sub-modules SHALL be used; the FSM and byte latches are single-level.

Verification
REQ-029 Stash, Length1=0 then 1, BA=1, C64DI=5A -> REUWR with REUDO=5A; one NextCA/NextREUA pulse, then XferEnd; total 4 cycles.
REQ-030 Swap, C64DI=11, REUDI=22 -> C64DO=22 in C64WR and REUDO=11 in REUWR; Length1=1 gives XferEnd after 4 cycles.
REQ-031 Verify, C64DI=33, REUDI=34 -> VerifyErr pulse, no XferEnd, nDMA=1 on the next cycle.
REQ-032 FF00Decode=1, Start, FF00Hit 5 cycles later -> nDMA stays 1 for 5 cycles, then fetch proceeds.
REQ-033 BA=0 for 3 cycles during C64WR -> state holds, no strobes; completes once BA=1.
REQ-034 Reset asserted mid-swap -> next edge IDLE, nDMA=1, Busy=0; a new Start then runs normally.

Source files
------------

// File: rtl/reu_pkg.sv
// Shared definitions for the REU transfer sequencer.
//   state_t     : one-hot-free encoding of the sequencer states
//   xfer_t      : transfer type codes as written to the REU command register
//   first_state : access that opens every byte for a given transfer type
package reu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_C64RD = 3'd2,
    S_REURD = 3'd3,
    S_C64WR = 3'd4,
    S_REUWR = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    XT_STASH  = 2'b00,
    XT_FETCH  = 2'b01,
    XT_SWAP   = 2'b10,
    XT_VERIFY = 2'b11
  } xfer_t;

  // Fetch is the only type that starts on the REU side.
  function automatic state_t first_state(input xfer_t xt);
    return (xt == XT_FETCH) ? S_REURD : S_C64RD;
  endfunction

endpackage

// File: rtl/reu_xfer_seq.sv
// REU DMA byte-transfer sequencer.
// Walks the per-byte access sequence for stash/fetch/swap/verify, one PHI2
// cycle per access, holding the two byte latches that carry data between the
// C64 bus and REU RAM. Everything updates on the falling edge of PHI2.
//
// Inputs : PHI2 (clock), Reset (sync, active-high), Start, FF00Decode,
//          FF00Hit, XferType[1:0], Length1, BA, C64DI[7:0], REUDI[7:0]
// Outputs: nDMA, C64AOE, C64RnW, C64DO[7:0], C64DOE, REURD, REUWR,
//          REUDO[7:0], NextCA, NextREUA, XferEnd, VerifyErr, Busy
//          (all driven straight from registers)
module reu_xfer_seq
  import reu_pkg::*;
(
  input  logic       PHI2,
  input  logic       Reset,
  input  logic       Start,
  input  logic       FF00Decode,
  input  logic       FF00Hit,
  input  logic [1:0] XferType,
  input  logic       Length1,
  input  logic       BA,
  input  logic [7:0] C64DI,
  input  logic [7:0] REUDI,
  output logic       nDMA,
  output logic       C64AOE,
  output logic       C64RnW,
  output logic [7:0] C64DO,
  output logic       C64DOE,
  output logic       REURD,
  output logic       REUWR,
  output logic [7:0] REUDO,
  output logic       NextCA,
  output logic       NextREUA,
  output logic       XferEnd,
  output logic       VerifyErr,
  output logic       Busy
);

  xfer_t  xt;
  state_t state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic ndma_q, aoe_q, rnw_q, doe_q, rd_q, wr_q, next_q, end_q, verr_q, busy_q;
  logic aoe_d, next_d, end_d, verr_d, byte_done, c64_d, wr64_d;

  assign xt = xfer_t'(XferType);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    next_d    = 1'b0;
    end_d     = 1'b0;
    verr_d    = 1'b0;
    byte_done = 1'b0;
    unique case (state_q)
      S_IDLE:  if (Start) state_d = FF00Decode ? S_ARM : first_state(xt);
      S_ARM:   if (FF00Hit) state_d = first_state(xt);
      // A C64 access completes only at the end of a cycle in which the bus
      // was actually driven; otherwise the state is simply repeated.
      S_C64RD: if (aoe_q) begin
        a_d     = C64DI;
        state_d = (xt == XT_STASH) ? S_REUWR : S_REURD;
      end
      S_REURD: begin
        b_d = REUDI;
        if (xt == XT_FETCH || xt == XT_SWAP) state_d = S_C64WR;
        else if (xt == XT_VERIFY && REUDI != a_q) begin
          // Mismatch aborts the transfer ahead of any end-of-length handling.
          verr_d  = 1'b1;
          state_d = S_IDLE;
        end else byte_done = 1'b1;
      end
      S_C64WR: if (aoe_q) begin
        if (xt == XT_SWAP) state_d = S_REUWR;
        else byte_done = 1'b1;
      end
      S_REUWR: byte_done = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (byte_done) begin
      if (Length1) begin
        end_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        next_d  = 1'b1;
        state_d = first_state(xt);
      end
    end
  end

  // Bus-side controls for the state being entered, sampled with BA now.
  assign c64_d  = (state_d == S_C64RD) || (state_d == S_C64WR);
  assign aoe_d  = c64_d && BA;
  assign wr64_d = (state_d == S_C64WR) && BA;

  always_ff @(negedge PHI2) begin
    if (Reset) begin
      state_q <= S_IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      ndma_q  <= 1'b1;
      aoe_q   <= 1'b0;
      rnw_q   <= 1'b1;
      doe_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      next_q  <= 1'b0;
      end_q   <= 1'b0;
      verr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ndma_q  <= (state_d == S_IDLE) || (state_d == S_ARM);
      aoe_q   <= aoe_d;
      rnw_q   <= !wr64_d;
      doe_q   <= wr64_d;
      rd_q    <= (state_d == S_REURD);
      wr_q    <= (state_d == S_REUWR);
      next_q  <= next_d;
      end_q   <= end_d;
      verr_q  <= verr_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign nDMA      = ndma_q;
  assign C64AOE    = aoe_q;
  assign C64RnW    = rnw_q;
  assign C64DO     = b_q;
  assign C64DOE    = doe_q;
  assign REURD     = rd_q;
  assign REUWR     = wr_q;
  assign REUDO     = a_q;
  assign NextCA    = next_q;
  assign NextREUA  = next_q;
  assign XferEnd   = end_q;
  assign VerifyErr = verr_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_reu_xfer_seq.sv
// Bench for reu_xfer_seq: directed scenarios plus a randomized run, each
// checked against a transfer-level model (phase, step index into the
// per-type access list, and the two byte latches).
module tb_reu_xfer_seq;

  logic       PHI2 = 1'b0;
  logic       Reset = 1'b1, Start = 1'b0, FF00Decode = 1'b0, FF00Hit = 1'b0;
  logic [1:0] XferType = 2'b00;
  logic       Length1 = 1'b0, BA = 1'b1;
  logic [7:0] C64DI = 8'h00, REUDI = 8'h00;
  logic       nDMA, C64AOE, C64RnW, C64DOE, REURD, REUWR;
  logic [7:0] C64DO, REUDO;
  logic       NextCA, NextREUA, XferEnd, VerifyErr, Busy;

  int total = 0;
  int bad = 0;

  reu_xfer_seq dut (
    .PHI2(PHI2), .Reset(Reset), .Start(Start), .FF00Decode(FF00Decode),
    .FF00Hit(FF00Hit), .XferType(XferType), .Length1(Length1), .BA(BA),
    .C64DI(C64DI), .REUDI(REUDI), .nDMA(nDMA), .C64AOE(C64AOE),
    .C64RnW(C64RnW), .C64DO(C64DO), .C64DOE(C64DOE), .REURD(REURD),
    .REUWR(REUWR), .REUDO(REUDO), .NextCA(NextCA), .NextREUA(NextREUA),
    .XferEnd(XferEnd), .VerifyErr(VerifyErr), .Busy(Busy)
  );

  always #5 PHI2 = ~PHI2;

  // ---------------- reference model ----------------
  // Access kinds: 0 C64 read, 1 REU read, 2 C64 write, 3 REU write.
  // Phase: 0 idle, 1 armed, 2 transferring.
  int         m_phase = 0;
  int         m_k = 0;
  logic [7:0] m_a = 8'h00, m_b = 8'h00;
  logic       m_next = 1'b0, m_end = 1'b0, m_verr = 1'b0, m_bus = 1'b0;

  function automatic int seq_kind(input logic [1:0] t, input int k);
    case (t)
      2'b00:   return (k == 0) ? 0 : 3;
      2'b01:   return (k == 0) ? 1 : 2;
      2'b10:   return k;
      default: return (k == 0) ? 0 : 1;
    endcase
  endfunction

  function automatic int seq_len(input logic [1:0] t);
    return (t == 2'b10) ? 4 : 2;
  endfunction

  function automatic int cur_kind();
    return (m_phase == 2) ? seq_kind(XferType, m_k) : -1;
  endfunction

  task automatic model_step();
    int  kind;
    bit  go;
    m_next = 1'b0; m_end = 1'b0; m_verr = 1'b0;
    if (Reset) begin
      m_phase = 0; m_k = 0; m_a = 8'h00; m_b = 8'h00; m_bus = 1'b0;
      return;
    end
    if (m_phase == 0) begin
      if (Start) begin m_phase = FF00Decode ? 1 : 2; m_k = 0; end
    end else if (m_phase == 1) begin
      if (FF00Hit) begin m_phase = 2; m_k = 0; end
    end else begin
      kind = seq_kind(XferType, m_k);
      go = (kind == 0 || kind == 2) ? m_bus : 1'b1;
      if (go) begin
        if (kind == 0) m_a = C64DI;
        if (kind == 1) m_b = REUDI;
        if (kind == 1 && XferType == 2'b11 && REUDI != m_a) begin
          m_verr = 1'b1; m_phase = 0;
        end else if (m_k == seq_len(XferType) - 1) begin
          if (Length1) begin m_end = 1'b1; m_phase = 0; end
          else begin m_next = 1'b1; m_k = 0; end
        end else m_k = m_k + 1;
      end
    end
    kind  = cur_kind();
    m_bus = (kind == 0 || kind == 2) && BA;
  endtask

  function automatic logic [26:0] expv();
    int k;
    k = cur_kind();
    return {m_phase != 2, m_bus, !(k == 2 && m_bus), m_b, (k == 2 && m_bus),
            k == 1, k == 3, m_a, m_next, m_next, m_end, m_verr, m_phase != 0};
  endfunction

  function automatic logic [26:0] obs();
    return {nDMA, C64AOE, C64RnW, C64DO, C64DOE, REURD, REUWR, REUDO,
            NextCA, NextREUA, XferEnd, VerifyErr, Busy};
  endfunction

  // One PHI2 cycle: inputs were set after the previous rising edge; the DUT
  // and model both act on the falling edge; results are read on the rising.
  task automatic tick();
    @(negedge PHI2);
    model_step();
    @(posedge PHI2);
  endtask

  localparam logic [26:0] RESET_VEC = {1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0,
                                       1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; FF00Hit = 1'b1;
    tick(); tick();
    total++;
    if (obs() !== RESET_VEC) begin
      bad++; $display("FAIL reset_state got=%h want=%h", obs(), RESET_VEC);
    end
    Reset = 1'b0; Start = 1'b0; FF00Hit = 1'b0;
    tick();
    total++;
    if (obs() !== expv()) begin
      bad++; $display("FAIL reset_idle got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_stash();
    int busy_n = 0, next_n = 0, end_n = 0;
    XferType = 2'b00; Length1 = 1'b0; BA = 1'b1; C64DI = 8'h5A; Start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      Start = 1'b0;
      if (i == 2) Length1 = 1'b1;
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL stash_cyc%0d got=%h want=%h", i, obs(), expv());
      end
      busy_n += int'(Busy); next_n += int'(NextCA && NextREUA); end_n += int'(XferEnd);
      if (REUWR) begin
        total++;
        if (REUDO !== 8'h5A) begin
          bad++; $display("FAIL stash_reudo got=%h want=5a", REUDO);
        end
      end
    end
    total++;
    if (busy_n != 4 || next_n != 1 || end_n != 1) begin
      bad++; $display("FAIL stash_counts got=%0d/%0d/%0d want=4/1/1", busy_n, next_n, end_n);
    end
  endtask

  task automatic test_swap();
    int busy_n = 0, end_n = 0;
    XferType = 2'b10; Length1 = 1'b1; C64DI = 8'h11; REUDI = 8'h22; Start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      Start = 1'b0;
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL swap_cyc%0d got=%h want=%h", i, obs(), expv());
      end
      busy_n += int'(Busy); end_n += int'(XferEnd);
      if (C64DOE) begin
        total++;
        if (C64DO !== 8'h22) begin bad++; $display("FAIL swap_c64do got=%h want=22", C64DO); end
      end
      if (REUWR) begin
        total++;
        if (REUDO !== 8'h11) begin bad++; $display("FAIL swap_reudo got=%h want=11", REUDO); end
      end
    end
    total++;
    if (busy_n != 4 || end_n != 1) begin
      bad++; $display("FAIL swap_counts got=%0d/%0d want=4/1", busy_n, end_n);
    end
  endtask

  task automatic test_verify(input logic [7:0] reu, input int want_err);
    int err_n = 0, end_n = 0, next_n = 0;
    XferType = 2'b11; Length1 = 1'b1; C64DI = 8'h33; REUDI = reu; Start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      Start = 1'b0;
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL verify_cyc%0d got=%h want=%h", i, obs(), expv());
      end
      err_n += int'(VerifyErr); end_n += int'(XferEnd); next_n += int'(NextCA);
      if (VerifyErr) begin
        total++;
        if (nDMA !== 1'b1) begin bad++; $display("FAIL verify_ndma got=%b want=1", nDMA); end
      end
    end
    total++;
    if (err_n != want_err || end_n != 1 - want_err || next_n != 0) begin
      bad++; $display("FAIL verify_counts got=%0d/%0d/%0d want=%0d/%0d/0",
                      err_n, end_n, next_n, want_err, 1 - want_err);
    end
  endtask

  task automatic test_arm();
    XferType = 2'b01; Length1 = 1'b1; FF00Decode = 1'b1; REUDI = 8'h9C; Start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      Start = 1'b0;
      if (i == 4) FF00Hit = 1'b1;
      total++;
      if (nDMA !== 1'b1 || Busy !== 1'b1 || obs() !== expv()) begin
        bad++; $display("FAIL arm_wait%0d got=%h want=%h", i, obs(), expv());
      end
    end
    tick();
    FF00Hit = 1'b0; FF00Decode = 1'b0;
    total++;
    if (REURD !== 1'b1 || nDMA !== 1'b0) begin
      bad++; $display("FAIL arm_go got=%b%b want=10", REURD, nDMA);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL arm_fetch%0d got=%h want=%h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_ba_stall();
    XferType = 2'b01; Length1 = 1'b1; BA = 1'b1; REUDI = 8'hA5; Start = 1'b1;
    tick();
    Start = 1'b0; BA = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (C64RnW !== 1'b1 || C64DOE !== 1'b0 || C64AOE !== 1'b0 || Busy !== 1'b1 ||
          XferEnd !== 1'b0 || obs() !== expv()) begin
        bad++; $display("FAIL stall%0d got=%h want=%h", i, obs(), expv());
      end
    end
    BA = 1'b1;
    tick();
    total++;
    if (C64DOE !== 1'b1 || C64RnW !== 1'b0 || C64DO !== 8'hA5 || obs() !== expv()) begin
      bad++; $display("FAIL stall_write got=%h want=%h", obs(), expv());
    end
    tick();
    total++;
    if (XferEnd !== 1'b1 || Busy !== 1'b0 || obs() !== expv()) begin
      bad++; $display("FAIL stall_end got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_reset_mid();
    int busy_n = 0;
    XferType = 2'b10; Length1 = 1'b0; C64DI = 8'h77; REUDI = 8'h88; Start = 1'b1;
    tick(); Start = 1'b0; tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    total++;
    if (obs() !== RESET_VEC) begin
      bad++; $display("FAIL reset_mid got=%h want=%h", obs(), RESET_VEC);
    end
    XferType = 2'b00; Length1 = 1'b1; C64DI = 8'hC3; Start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      Start = 1'b0;
      busy_n += int'(Busy);
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL after_reset%0d got=%h want=%h", i, obs(), expv());
      end
    end
    total++;
    if (busy_n != 2) begin bad++; $display("FAIL after_reset_busy got=%0d want=2", busy_n); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      Reset      = ($urandom_range(0, 99) == 0);
      Start      = ($urandom_range(0, 5) == 0);
      FF00Hit    = ($urandom_range(0, 3) == 0);
      Length1    = ($urandom_range(0, 2) == 0);
      BA         = ($urandom_range(0, 3) != 0);
      C64DI      = 8'($urandom);
      REUDI      = ($urandom_range(0, 1) == 0) ? m_a : 8'($urandom);
      if (m_phase == 0) begin
        XferType   = 2'($urandom);
        FF00Decode = ($urandom_range(0, 3) == 0);
      end
      tick();
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL random%0d got=%h want=%h", i, obs(), expv());
      end
    end
    Reset = 1'b0; Start = 1'b0; FF00Hit = 1'b0;
  endtask

  initial begin
    @(posedge PHI2);
    test_reset();
    test_stash();
    test_swap();
    test_verify(8'h34, 1);
    test_verify(8'h33, 0);
    test_arm();
    test_ba_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
